load_fire_scheduler: RTL
========================

LOAD_FIRE_SCHEDULER -- requirements
Module: load_fire_scheduler

Interface
REQ-001 SHALL have these parameters (name, default, meaning): XLEN, 32, address width; ROB_TAG_WIDTH, 32, ROB tag width; LDQ_SIZE, 32, load queue entries (power of 2); STQ_SIZE, 32, store queue entries (power of 2).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ldq_valid  in  LDQ_SIZE  LDQ entry allocated
- ldq_address_valid  in  LDQ_SIZE  entry address computed
- ldq_head  in  clog2(LDQ_SIZE)  oldest LDQ entry
- kill_mem_req  in  1  from dependence checker, same cycle as load_fired
- sleep  in  1  from dependence checker
- sleep_rob_tag  in  ROB_TAG_WIDTH  store ROB tag the load waits on
- forward  in  1  from dependence checker
- stq_forward_index  in  clog2(STQ_SIZE)  forwarding store index
- wake_valid  in  1  store data broadcast valid
- wake_rob_tag  in  ROB_TAG_WIDTH  ROB tag of broadcast store
- mem_req_ready  in  1  L1 accepts a request this cycle
- mem_resp_valid  in  1  L1 returns load data
- mem_resp_ldq_index  in  clog2(LDQ_SIZE)  LDQ entry of the response
- load_fired  out  1  a load is fired this cycle (to checker)
- load_fired_ldq_index  out  clog2(LDQ_SIZE)  fired entry
- mem_req_valid  out  1  request to L1
- mem_req_ldq_index  out  clog2(LDQ_SIZE)  LDQ index of the request
- load_done_valid  out  1  registered completion pulse
- load_done_ldq_index  out  clog2(LDQ_SIZE)  completed entry
- load_done_forwarded  out  1  completion came from store forwarding
- load_done_stq_index  out  clog2(STQ_SIZE)  forwarding store (valid when forwarded)
- ldq_sleeping  out  LDQ_SIZE  entry currently in SLEEP

Function
REQ-003 SHALL keep a per-entry state: IDLE, WAIT_ADDR, READY, INFLIGHT, SLEEP, DONE.
REQ-004 SHALL force the state to IDLE in any cycle ldq_valid[i]=0, overriding all other transitions (this is the flush/commit path).
REQ-005 SHALL apply these transitions: IDLE->WAIT_ADDR on ldq_valid; WAIT_ADDR->READY on ldq_address_valid; IDLE->READY directly if both bits are set.
REQ-006 SHALL combinationally select the READY entry oldest by distance (i - ldq_head) mod LDQ_SIZE, with wrap-around.
REQ-007 SHALL assert load_fired when a READY entry exists, mem_req_ready=1 and mem_resp_valid=0; load_fired_ldq_index SHALL be the selected entry.
REQ-008 SHALL drive mem_req_valid = load_fired & ~kill_mem_req, with mem_req_ldq_index = load_fired_ldq_index.
REQ-009 SHALL update the fired entry at the next edge as follows:
- no kill: -> INFLIGHT
- kill & forward: -> DONE
- kill & sleep: -> SLEEP, latching sleep_rob_tag
- kill with neither forward nor sleep: -> READY
REQ-010 SHALL move a SLEEP entry whose latched tag equals wake_rob_tag while wake_valid=1 to READY.
REQ-011 SHALL send a load directly to READY if it is put to sleep in the same cycle a wake_valid carries a matching tag.
REQ-012 SHALL move the INFLIGHT entry at mem_resp_ldq_index to DONE on mem_resp_valid; a response to a non-INFLIGHT entry SHALL be ignored.
REQ-013 SHALL register load_done_* one cycle after either completion source (forward per REQ-009, response per REQ-012).
REQ-014 SHALL hold load_done_forwarded=1 and load_done_stq_index = stq_forward_index for a forwarded completion.
REQ-015 SHALL drive load_done_forwarded=0 and load_done_stq_index=0 for a memory-response completion.
REQ-016 SHALL never produce both completion sources in one cycle; REQ-007 guarantees this.
REQ-017 SHALL keep DONE until ldq_valid drops, and SHALL never re-fire a DONE entry.
REQ-018 SHALL drive ldq_sleeping[i]=1 exactly when entry i is in SLEEP.

Reset
REQ-019 SHALL, while reset_n=0, set all entries to IDLE, clear latched tags and timers, and drive every registered output to 0; load_fired and mem_req_valid SHALL read 0.
REQ-020 SHALL discard loads in flight when reset is asserted; a mem_resp_valid arriving after reset SHALL be ignored per REQ-012.

Configuration
REQ-021 SHALL, with macro LOAD_SLEEP_TIMEOUT_EN defined, give each entry a 4-bit counter that clears on entry to SLEEP and increments every cycle in SLEEP; on reaching 15 the entry SHALL move to READY.
REQ-022 SHALL, without LOAD_SLEEP_TIMEOUT_EN, contain no counters; SLEEP SHALL exit only via wake or ldq_valid=0.

Verification
REQ-023 SHALL cover: entries 2,5 READY, ldq_head=4, no kill -> load_fired index 5, then 2; responses give load_done pulses for 5 then 2, forwarded=0.
REQ-024 SHALL cover: fire entry 3 with kill=1, forward=1, stq_forward_index=7 -> mem_req_valid=0; next cycle load_done_valid=1, index 3, forwarded=1, stq index 7.
REQ-025 SHALL cover: fire entry 1 with kill=1, sleep=1, tag 0x2A -> ldq_sleeping[1]=1; wake tag 0x29 -> stays asleep; wake tag 0x2A -> refires the next eligible cycle.
REQ-026 SHALL cover: sleep and a matching wake in the same cycle -> entry is READY next cycle and ldq_sleeping[1] never rises.
REQ-027 SHALL cover: ldq_valid[6] dropped while entry 6 is INFLIGHT, then mem_resp for 6 -> no load_done.
REQ-028 SHALL cover: reset_n pulsed low mid-flight -> all outputs 0 immediately; with LOAD_SLEEP_TIMEOUT_EN, an unwoken sleeper returns to READY after 15 cycles.

Source files
------------

// File: rtl/load_fire_scheduler.sv
// rtl/load_fire_scheduler.sv - per-entry load fire scheduler with sleep/wake and completion reporting
// Optional build macro: LOAD_SLEEP_TIMEOUT_EN (4-bit per-entry sleep timeout back to READY).
// Ports: clk, reset_n (async, active-low); ldq_valid/ldq_address_valid/ldq_head (LDQ status);
// kill_mem_req/sleep/sleep_rob_tag/forward/stq_forward_index (dependence checker verdict);
// wake_valid/wake_rob_tag (store data broadcast); mem_req_ready/mem_resp_valid/mem_resp_ldq_index (L1);
// load_fired/load_fired_ldq_index, mem_req_valid/mem_req_ldq_index (fire), load_done_* (registered
// completion), ldq_sleeping (per-entry SLEEP flag).
module load_fire_scheduler #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int LDQ_SIZE      = 32,
    parameter int STQ_SIZE      = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LDQ_SIZE-1:0]         ldq_valid,
    input  logic [LDQ_SIZE-1:0]         ldq_address_valid,
    input  logic [$clog2(LDQ_SIZE)-1:0] ldq_head,
    input  logic                        kill_mem_req,
    input  logic                        sleep,
    input  logic [ROB_TAG_WIDTH-1:0]    sleep_rob_tag,
    input  logic                        forward,
    input  logic [$clog2(STQ_SIZE)-1:0] stq_forward_index,
    input  logic                        wake_valid,
    input  logic [ROB_TAG_WIDTH-1:0]    wake_rob_tag,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [$clog2(LDQ_SIZE)-1:0] mem_resp_ldq_index,
    output logic                        load_fired,
    output logic [$clog2(LDQ_SIZE)-1:0] load_fired_ldq_index,
    output logic                        mem_req_valid,
    output logic [$clog2(LDQ_SIZE)-1:0] mem_req_ldq_index,
    output logic                        load_done_valid,
    output logic [$clog2(LDQ_SIZE)-1:0] load_done_ldq_index,
    output logic                        load_done_forwarded,
    output logic [$clog2(STQ_SIZE)-1:0] load_done_stq_index,
    output logic [LDQ_SIZE-1:0]         ldq_sleeping
);

    localparam int LW = $clog2(LDQ_SIZE);
    localparam int SW = $clog2(STQ_SIZE);

    // Index arithmetic relies on natural wrap of LW/SW-bit values.
    if (XLEN < 1 || LDQ_SIZE != (1 << LW) || STQ_SIZE != (1 << SW)) begin : g_bad_params
        $error("load_fire_scheduler: queue sizes must be powers of two");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ADDR,
        ST_READY,
        ST_INFLIGHT,
        ST_SLEEP,
        ST_DONE
    } entry_state_e;

    entry_state_e             state_q [LDQ_SIZE];
    entry_state_e             state_d [LDQ_SIZE];
    logic [ROB_TAG_WIDTH-1:0] tag_q   [LDQ_SIZE];
    logic [ROB_TAG_WIDTH-1:0] tag_d   [LDQ_SIZE];
    logic                     sel_found;
    logic [LW-1:0]            sel_idx;
    logic [LW-1:0]            cand;
    logic                     fwd_done;
    logic                     resp_done;

`ifdef LOAD_SLEEP_TIMEOUT_EN
    logic [3:0] sleep_cnt_q [LDQ_SIZE];

    // Counter is held at zero outside SLEEP, so it restarts on every entry to SLEEP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LDQ_SIZE; i++) sleep_cnt_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < LDQ_SIZE; i++)
                sleep_cnt_q[i] <= (state_q[i] == ST_SLEEP) ? sleep_cnt_q[i] + 4'd1 : 4'd0;
        end
    end
`endif

    // Walk from the head outward; the first READY hit is the oldest.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int d = 0; d < LDQ_SIZE; d++) begin
            cand = ldq_head + LW'(d);
            if (!sel_found && state_q[cand] == ST_READY) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // A returning response owns the L1 port this cycle, which also keeps the
    // forward and response completion sources mutually exclusive.
    assign load_fired           = sel_found & mem_req_ready & ~mem_resp_valid;
    assign load_fired_ldq_index = sel_idx;
    assign mem_req_valid        = load_fired & ~kill_mem_req;
    assign mem_req_ldq_index    = sel_idx;

    assign fwd_done  = load_fired & kill_mem_req & forward & ldq_valid[sel_idx];
    assign resp_done = mem_resp_valid & ldq_valid[mem_resp_ldq_index]
                     & (state_q[mem_resp_ldq_index] == ST_INFLIGHT);

    always_comb begin
        ldq_sleeping = '0;
        for (int i = 0; i < LDQ_SIZE; i++) ldq_sleeping[i] = (state_q[i] == ST_SLEEP);
    end

    always_comb begin
        for (int i = 0; i < LDQ_SIZE; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            if (!ldq_valid[i]) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE:      state_d[i] = ldq_address_valid[i] ? ST_READY : ST_WAIT_ADDR;
                    ST_WAIT_ADDR: if (ldq_address_valid[i]) state_d[i] = ST_READY;
                    ST_READY: begin
                        if (load_fired && sel_idx == LW'(i)) begin
                            if (!kill_mem_req) begin
                                state_d[i] = ST_INFLIGHT;
                            end else if (forward) begin
                                state_d[i] = ST_DONE;
                            end else if (sleep && !(wake_valid && wake_rob_tag == sleep_rob_tag)) begin
                                // A wake for the same tag this cycle would be missed, so only park otherwise.
                                state_d[i] = ST_SLEEP;
                                tag_d[i]   = sleep_rob_tag;
                            end
                        end
                    end
                    ST_INFLIGHT: begin
                        if (mem_resp_valid && mem_resp_ldq_index == LW'(i)) state_d[i] = ST_DONE;
                    end
                    ST_SLEEP: begin
                        if (wake_valid && wake_rob_tag == tag_q[i]) state_d[i] = ST_READY;
`ifdef LOAD_SLEEP_TIMEOUT_EN
                        // The counter reaches 15 on this edge.
                        if (sleep_cnt_q[i] == 4'd14) state_d[i] = ST_READY;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LDQ_SIZE; i++) begin
                state_q[i] <= ST_IDLE;
                tag_q[i]   <= '0;
            end
            load_done_valid     <= 1'b0;
            load_done_ldq_index <= '0;
            load_done_forwarded <= 1'b0;
            load_done_stq_index <= '0;
        end else begin
            for (int i = 0; i < LDQ_SIZE; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
            end
            load_done_valid     <= fwd_done | resp_done;
            load_done_ldq_index <= fwd_done ? sel_idx : (resp_done ? mem_resp_ldq_index : '0);
            load_done_forwarded <= fwd_done;
            load_done_stq_index <= fwd_done ? stq_forward_index : '0;
        end
    end

endmodule
